// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the 16-to-4 request encoder and its decoder-side models.
package req_enc_pkg;
  localparam int REQ_N  = 16;
  localparam int CODE_W = 4;

  typedef logic [REQ_N-1:0]  req_vec_t;
  typedef logic [CODE_W-1:0] code_t;

  function automatic req_vec_t onehot16(input code_t c);
    req_vec_t one;
    one = req_vec_t'(1);
    return one << c;
  endfunction
endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-input priority encoder: lowest set bit at or above start_i,
// wrapping to the lowest set bit overall when nothing is set above the start.
module prio_enc16
  import req_enc_pkg::*;
(
  input  req_vec_t vec_i,
  input  code_t    start_i,
  output logic     found_o,
  output code_t    idx_o
);
  req_vec_t hi;
  code_t    hi_idx, lo_idx;

  always_comb begin
    hi = '1;
    hi = hi << start_i;
    hi = hi & vec_i;
    hi_idx = '0;
    lo_idx = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = REQ_N-1; i >= 0; i--) begin
      if (hi[i])    hi_idx = code_t'(i);
      if (vec_i[i]) lo_idx = code_t'(i);
    end
    found_o = |vec_i;
    idx_o   = (|hi) ? hi_idx : lo_idx;
  end
endmodule

// File: rtl/req_encode16_4.sv
// Sequential 16-to-4 request encoder with pending capture, valid/ready issue and
// saturating merge counter. Define REQ_ENC_ROUND_ROBIN_EN for rotating priority.
module req_encode16_4
  import req_enc_pkg::*;
#(
  parameter int MERGE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  req_vec_t           req,
  output code_t              code,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy,
  output logic [MERGE_W-1:0] merge_cnt
);
  localparam logic [31:0] MERGE_MAX = (32'd1 << MERGE_W) - 32'd1;

  req_vec_t           pend_q, pend_d, cand, merged;
  code_t              code_q, code_d, sel_idx, start;
  logic               valid_q, valid_d, busy_q, busy_d, slot_free, sel_found;
  logic [MERGE_W-1:0] merge_q, merge_d;
  logic [4:0]         pop;
  logic [31:0]        msum;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  code_t ptr_q, ptr_d;
  assign start = ptr_q;
`else
  assign start = '0;
`endif

  prio_enc16 u_prio (
    .vec_i   (cand),
    .start_i (start),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_comb begin
    cand      = pend_q | req;
    merged    = pend_q & req;
    slot_free = !valid_q || ready_i;
    pend_d    = cand;
    code_d    = code_q;
    valid_d   = valid_q;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    if (slot_free) begin
      if (sel_found) begin
        code_d  = sel_idx;
        valid_d = 1'b1;
        pend_d  = cand & ~onehot16(sel_idx);
`ifdef REQ_ENC_ROUND_ROBIN_EN
        ptr_d   = sel_idx + code_t'(1);
`endif
      end else begin
        valid_d = 1'b0;
        pend_d  = '0;
      end
    end
    busy_d = (|pend_d) || valid_d;

    // Only bits already waiting in pend count as merges; the in-flight index does not.
    pop = '0;
    for (int i = 0; i < REQ_N; i++) pop = pop + {4'b0, merged[i]};
    msum    = 32'(merge_q) + 32'(pop);
    merge_d = (msum > MERGE_MAX) ? MERGE_MAX[MERGE_W-1:0] : msum[MERGE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      merge_q <= '0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
      ptr_q   <= '0;
`endif
    end else begin
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      merge_q <= merge_d;
`ifdef REQ_ENC_ROUND_ROBIN_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign code      = code_q;
  assign valid_o   = valid_q;
  assign busy      = busy_q;
  assign merge_cnt = merge_q;
endmodule
